// File: rtl/fir_stream_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_stream_driver_if                                                 |
// | Host byte handshake plus the FIR-side beat bus (x_n/tvalid/coeffs).  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fir_stream_driver_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x_n;
  logic              s_axis_fir_tvalid;
  logic              s_set_coeffs;

  // The host side drives bytes in and observes the FIR-side beats.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  x_n,
    input  s_axis_fir_tvalid,
    input  s_set_coeffs
  );

  // The driver accepts host bytes and produces the FIR-side beats.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output x_n,
    output s_axis_fir_tvalid,
    output s_set_coeffs
  );
endinterface
`default_nettype wire

// File: rtl/fir_stream_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_stream_driver                                                    |
// | Buffers host bytes and paces them to the FIR as samples/coeffs.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fir_stream_driver #(
  parameter int DATA_W     = 8,
  parameter int NUM_TAPS   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int SAMPLE_DIV = 1
) (
  input  wire logic                               clk,
  input  wire logic                               reset,
  fir_stream_driver_if.slave                      bus,
  input  wire logic                               load_req,
  output logic                                    coeff_done,
  output logic                                    load_err,
  output logic                                    overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]         fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int GAP_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(SAMPLE_DIV - 1);
  localparam logic [TAP_W-1:0] TAP_LAST   = TAP_W'(NUM_TAPS - 1);

  localparam logic [0:0] ST_STREAM = 1'b0;
  localparam logic [0:0] ST_LOAD   = 1'b1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [GAP_W-1:0]  gap;
  logic [TAP_W-1:0]  tap;
  logic [0:0]        state;
  logic [0:0]        state_nxt;

  logic [DATA_W-1:0] x_n_q;
  logic              tvalid_q;
  logic              set_coeffs_q;

  logic full;
  logic empty;
  logic push;
  logic beat;
  logic last_coeff;
  logic load_ok;

  // in_ready comes from the registered level, so a same-edge pop never frees a slot early.
  assign full       = (level == LVL_FULL);
  assign empty      = (level == '0);
  assign push       = bus.in_valid && !full;
  assign beat       = !empty && (gap == '0);
  assign last_coeff = (state == ST_LOAD) && beat && (tap == TAP_LAST);
  assign load_ok    = load_req && (state == ST_STREAM) && empty;

  assign bus.in_ready          = !full;
  assign bus.x_n               = x_n_q;
  assign bus.s_axis_fir_tvalid = tvalid_q;
  assign bus.s_set_coeffs      = set_coeffs_q;
  assign fifo_level            = level;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STREAM: if (load_ok)    state_nxt = ST_LOAD;
      ST_LOAD:   if (last_coeff) state_nxt = ST_STREAM;
      default:                   state_nxt = ST_STREAM;
    endcase
  end

  // Storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (beat) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, beat})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap <= '0;
    end else if (beat) begin
      gap <= GAP_RELOAD;
    end else if (gap != '0) begin
      gap <= gap - GAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_STREAM;
      tap   <= '0;
    end else begin
      state <= state_nxt;
      if (load_ok) begin
        tap <= '0;
      end else if ((state == ST_LOAD) && beat) begin
        tap <= last_coeff ? '0 : tap + TAP_W'(1);
      end
    end
  end

  // set_coeffs stays high for the cycle that presents the final coefficient.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_n_q        <= '0;
      tvalid_q     <= 1'b0;
      set_coeffs_q <= 1'b0;
      coeff_done   <= 1'b0;
      load_err     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (beat) x_n_q <= mem[rd_ptr];
      tvalid_q     <= beat;
      set_coeffs_q <= (state_nxt == ST_LOAD) || last_coeff;
      coeff_done   <= last_coeff;
      load_err     <= load_req && !load_ok;
      overflow     <= overflow || (bus.in_valid && full);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fir_stream_driver                                                 |
// | Directed bench over three pacing configurations (div 1, 16, 3).      |
// +----------------------------------------------------------------------+
module tb_fir_stream_driver;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fir_stream_driver_if #(.DATA_W(8)) bus1 ();
  fir_stream_driver_if #(.DATA_W(8)) bus16 ();
  fir_stream_driver_if #(.DATA_W(8)) bus3 ();

  logic       load_req1, coeff_done1, load_err1, overflow1;
  logic [3:0] level1;
  logic       load_req16, coeff_done16, load_err16, overflow16;
  logic [3:0] level16;
  logic       load_req3, coeff_done3, load_err3, overflow3;
  logic [3:0] level3;

  fir_stream_driver #(.DATA_W(8), .NUM_TAPS(4), .FIFO_DEPTH(8), .SAMPLE_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .load_req(load_req1),
    .coeff_done(coeff_done1), .load_err(load_err1), .overflow(overflow1), .fifo_level(level1)
  );
  fir_stream_driver #(.DATA_W(8), .NUM_TAPS(4), .FIFO_DEPTH(8), .SAMPLE_DIV(16)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16), .load_req(load_req16),
    .coeff_done(coeff_done16), .load_err(load_err16), .overflow(overflow16), .fifo_level(level16)
  );
  fir_stream_driver #(.DATA_W(8), .NUM_TAPS(4), .FIFO_DEPTH(8), .SAMPLE_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .load_req(load_req3),
    .coeff_done(coeff_done3), .load_err(load_err3), .overflow(overflow3), .fifo_level(level3)
  );

  // Outputs are observed 1ns after the edge that produced them.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus1.in_valid = 1'b0;  bus1.in_data = 8'h00;  load_req1 = 1'b0;
    bus16.in_valid = 1'b0; bus16.in_data = 8'h00; load_req16 = 1'b0;
    bus3.in_valid = 1'b0;  bus3.in_data = 8'h00;  load_req3 = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'hFF;
    step();
    step();
    bus1.in_valid = 1'b0;
    reset = 1'b0;
    tests++; if (bus1.x_n !== 8'h00) begin fails++; $display("FAIL reset_x_n: got %h expected 00", bus1.x_n); end
    tests++; if (bus1.s_axis_fir_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b expected 0", bus1.s_axis_fir_tvalid); end
    tests++; if (bus1.s_set_coeffs !== 1'b0) begin fails++; $display("FAIL reset_set_coeffs: got %b expected 0", bus1.s_set_coeffs); end
    tests++; if ({coeff_done1, load_err1, overflow1} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b expected 000", {coeff_done1, load_err1, overflow1}); end
    tests++; if (level1 !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", level1); end
    tests++; if (bus1.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", bus1.in_ready); end
  endtask

  task automatic test_stream();
    logic [7:0] din [5];
    logic       vin [5];
    logic       etv [5];
    logic [7:0] ex  [5];
    din = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
    vin = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    etv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ex  = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h33};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus1.in_valid = vin[i];
      bus1.in_data  = din[i];
      step();
      tests++;
      if (bus1.s_axis_fir_tvalid !== etv[i] || bus1.x_n !== ex[i] || bus1.s_set_coeffs !== 1'b0) begin
        fails++;
        $display("FAIL stream[%0d]: got tv=%b x=%h sc=%b expected tv=%b x=%h sc=0",
                 i, bus1.s_axis_fir_tvalid, bus1.x_n, bus1.s_set_coeffs, etv[i], ex[i]);
      end
    end
    bus1.in_valid = 1'b0;
  endtask

  task automatic test_coeff_load();
    logic [7:0] din [8];
    logic       vin [8];
    logic       etv [8];
    logic [7:0] ex  [8];
    logic       esc [8];
    logic       edn [8];
    din = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
    vin = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    etv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ex  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h06};
    esc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    edn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    load_req1 = 1'b1;
    step();
    load_req1 = 1'b0;
    tests++;
    if (bus1.s_set_coeffs !== 1'b1 || load_err1 !== 1'b0) begin
      fails++;
      $display("FAIL load_accept: got sc=%b err=%b expected sc=1 err=0", bus1.s_set_coeffs, load_err1);
    end
    for (int i = 0; i < 8; i++) begin
      bus1.in_valid = vin[i];
      bus1.in_data  = din[i];
      step();
      tests++;
      if (bus1.s_axis_fir_tvalid !== etv[i] || bus1.x_n !== ex[i] ||
          bus1.s_set_coeffs !== esc[i] || coeff_done1 !== edn[i] || load_err1 !== 1'b0) begin
        fails++;
        $display("FAIL coeff[%0d]: got tv=%b x=%h sc=%b done=%b err=%b expected tv=%b x=%h sc=%b done=%b err=0",
                 i, bus1.s_axis_fir_tvalid, bus1.x_n, bus1.s_set_coeffs, coeff_done1, load_err1,
                 etv[i], ex[i], esc[i], edn[i]);
      end
    end
    bus1.in_valid = 1'b0;
  endtask

  task automatic test_load_err();
    bit         found;
    logic [7:0] got_x;
    do_reset();
    // Three pushes leave two bytes queued behind the first (already popped) one.
    for (int i = 0; i < 3; i++) begin
      bus16.in_valid = 1'b1;
      bus16.in_data  = 8'hA0 + 8'(i);
      step();
    end
    bus16.in_valid = 1'b0;
    load_req16 = 1'b1;
    step();
    load_req16 = 1'b0;
    tests++;
    if (load_err16 !== 1'b1 || bus16.s_set_coeffs !== 1'b0 || level16 !== 4'd2) begin
      fails++;
      $display("FAIL err_nonempty: got err=%b sc=%b lvl=%0d expected err=1 sc=0 lvl=2",
               load_err16, bus16.s_set_coeffs, level16);
    end
    step();
    tests++; if (load_err16 !== 1'b0) begin fails++; $display("FAIL err_pulse_width: got %b expected 0", load_err16); end
    found = 1'b0;
    got_x = 8'h00;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (bus16.s_axis_fir_tvalid === 1'b1) begin
        found = 1'b1;
        got_x = bus16.x_n;
      end
    end
    tests++;
    if (!found || got_x !== 8'hA1 || bus16.s_set_coeffs !== 1'b0) begin
      fails++;
      $display("FAIL err_stream_kept: got found=%b x=%h sc=%b expected found=1 x=a1 sc=0",
               found, got_x, bus16.s_set_coeffs);
    end

    load_req1 = 1'b1;
    step();
    tests++; if (bus1.s_set_coeffs !== 1'b1) begin fails++; $display("FAIL err_load_enter: got sc=%b expected 1", bus1.s_set_coeffs); end
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'h55;
    step();
    load_req1 = 1'b0;
    bus1.in_valid = 1'b0;
    tests++;
    if (load_err1 !== 1'b1 || bus1.s_set_coeffs !== 1'b1) begin
      fails++;
      $display("FAIL err_in_load: got err=%b sc=%b expected err=1 sc=1", load_err1, bus1.s_set_coeffs);
    end
    step();
    tests++;
    if (load_err1 !== 1'b0 || bus1.s_axis_fir_tvalid !== 1'b1 || bus1.x_n !== 8'h55 || bus1.s_set_coeffs !== 1'b1) begin
      fails++;
      $display("FAIL err_load_beat: got err=%b tv=%b x=%h sc=%b expected err=0 tv=1 x=55 sc=1",
               load_err1, bus1.s_axis_fir_tvalid, bus1.x_n, bus1.s_set_coeffs);
    end
  endtask

  task automatic test_overflow();
    bit         ovf_dropped;
    bit         found;
    logic [7:0] got_x;
    logic [3:0] exp_lvl;
    do_reset();
    bus16.in_valid = 1'b1;
    bus16.in_data  = 8'hC0;
    step();
    bus16.in_valid = 1'b0;
    step();
    tests++;
    if (bus16.s_axis_fir_tvalid !== 1'b1 || bus16.x_n !== 8'hC0 || level16 !== 4'd0) begin
      fails++;
      $display("FAIL ovf_first_beat: got tv=%b x=%h lvl=%0d expected tv=1 x=c0 lvl=0",
               bus16.s_axis_fir_tvalid, bus16.x_n, level16);
    end
    // The 15-cycle gap now holds off pops while nine bytes arrive.
    for (int k = 0; k < 9; k++) begin
      bus16.in_valid = 1'b1;
      bus16.in_data  = 8'hB0 + 8'(k);
      step();
      exp_lvl = (k < 8) ? 4'(k + 1) : 4'd8;
      tests++;
      if (level16 !== exp_lvl || bus16.in_ready !== (exp_lvl < 4'd8) || overflow16 !== (k == 8)) begin
        fails++;
        $display("FAIL ovf_push[%0d]: got lvl=%0d rdy=%b ovf=%b expected lvl=%0d rdy=%b ovf=%b",
                 k, level16, bus16.in_ready, overflow16, exp_lvl, (exp_lvl < 4'd8), (k == 8));
      end
    end
    bus16.in_valid = 1'b0;
    ovf_dropped = 1'b0;
    found = 1'b0;
    got_x = 8'h00;
    for (int c = 0; c < 20; c++) begin
      step();
      if (overflow16 !== 1'b1) ovf_dropped = 1'b1;
      if (!found && bus16.s_axis_fir_tvalid === 1'b1) begin
        found = 1'b1;
        got_x = bus16.x_n;
      end
    end
    tests++; if (ovf_dropped) begin fails++; $display("FAIL ovf_sticky: got cleared expected held at 1"); end
    tests++;
    if (!found || got_x !== 8'hB0) begin
      fails++;
      $display("FAIL ovf_order: got found=%b x=%h expected found=1 x=b0", found, got_x);
    end
    do_reset();
    tests++;
    if (overflow16 !== 1'b0 || level16 !== 4'd0) begin
      fails++;
      $display("FAIL ovf_reset: got ovf=%b lvl=%0d expected ovf=0 lvl=0", overflow16, level16);
    end
  endtask

  task automatic test_pacing();
    logic [7:0] din [4];
    int         nb;
    logic       etv;
    logic [7:0] ex;
    din = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    nb = 0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      bus3.in_valid = (i < 4);
      bus3.in_data  = (i < 4) ? din[i] : 8'h00;
      step();
      // Beats land on edges 2, 5, 8, 11 after the first push on edge 1.
      etv = (i == 1) || (i == 4) || (i == 7) || (i == 10);
      if (etv) nb++;
      ex = (nb == 0) ? 8'h00 : din[nb-1];
      tests++;
      if (bus3.s_axis_fir_tvalid !== etv || bus3.x_n !== ex || bus3.s_set_coeffs !== 1'b0) begin
        fails++;
        $display("FAIL pace[%0d]: got tv=%b x=%h sc=%b expected tv=%b x=%h sc=0",
                 i, bus3.s_axis_fir_tvalid, bus3.x_n, bus3.s_set_coeffs, etv, ex);
      end
    end
    bus3.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    bit   bad_idle;
    logic etv;
    logic edn;
    do_reset();
    load_req1 = 1'b1;
    step();
    load_req1 = 1'b0;
    bus1.in_valid = 1'b1; bus1.in_data = 8'h10; step();
    bus1.in_data = 8'h20; step();
    bus1.in_data = 8'h30; step();
    tests++;
    if (bus1.s_axis_fir_tvalid !== 1'b1 || bus1.x_n !== 8'h20 || bus1.s_set_coeffs !== 1'b1 || coeff_done1 !== 1'b0) begin
      fails++;
      $display("FAIL midload_two_beats: got tv=%b x=%h sc=%b done=%b expected tv=1 x=20 sc=1 done=0",
               bus1.s_axis_fir_tvalid, bus1.x_n, bus1.s_set_coeffs, coeff_done1);
    end
    bus1.in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if ({bus1.s_axis_fir_tvalid, bus1.s_set_coeffs, coeff_done1, load_err1, overflow1} !== 5'b00000 ||
        bus1.x_n !== 8'h00 || level1 !== 4'd0 || bus1.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midload_reset: got tv=%b sc=%b done=%b err=%b ovf=%b x=%h lvl=%0d rdy=%b expected all 0, rdy=1",
               bus1.s_axis_fir_tvalid, bus1.s_set_coeffs, coeff_done1, load_err1, overflow1,
               bus1.x_n, level1, bus1.in_ready);
    end
    bad_idle = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus1.s_axis_fir_tvalid !== 1'b0 || coeff_done1 !== 1'b0 || bus1.s_set_coeffs !== 1'b0) bad_idle = 1'b1;
    end
    tests++; if (bad_idle) begin fails++; $display("FAIL midload_idle: got activity after reset expected none"); end
    load_req1 = 1'b1;
    step();
    load_req1 = 1'b0;
    tests++;
    if (bus1.s_set_coeffs !== 1'b1 || load_err1 !== 1'b0) begin
      fails++;
      $display("FAIL midload_reload: got sc=%b err=%b expected sc=1 err=0", bus1.s_set_coeffs, load_err1);
    end
    for (int i = 0; i < 6; i++) begin
      bus1.in_valid = (i < 4);
      bus1.in_data  = 8'h41 + 8'(i);
      step();
      etv = (i >= 1) && (i <= 4);
      edn = (i == 4);
      tests++;
      if (bus1.s_axis_fir_tvalid !== etv || coeff_done1 !== edn) begin
        fails++;
        $display("FAIL midload_seq[%0d]: got tv=%b done=%b expected tv=%b done=%b",
                 i, bus1.s_axis_fir_tvalid, coeff_done1, etv, edn);
      end
    end
    bus1.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_stream();
    test_coeff_load();
    test_load_err();
    test_overflow();
    test_pacing();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
